alu_op_sequencer: RTL and testbench

//  Command-side initiator for the 8-bit ALU datapath (ripple-carry adder, subtracter, Booth radix-2

---
 rtl/alu_op_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 8-bit ALU units: one command in flight, valid/ready in and out.
// Optional divider watchdog enabled by defining ALU_SEQ_WATCHDOG_EN.
module alu_op_sequencer #(
   parameter int unsigned MULT_CYCLES = 11,
   parameter int unsigned DIV_TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic        cmd_cin,
   output logic [7:0]  op_a,
   output logic [7:0]  op_b,
   output logic        op_cin,
   input  logic [7:0]  add_sum,
   input  logic        add_cout,
   input  logic [7:0]  sub_diff,
   input  logic        sub_bout,
   output logic        mult_rst_n,
   input  logic [15:0] mult_product,
   output logic        div_reset,
   output logic        div_start,
   input  logic [7:0]  div_quotient,
   input  logic [7:0]  div_remainder,
   input  logic        div_busy,
   input  logic        div_by_zero,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        res_flag
);

   localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_TIMEOUT) ? MULT_CYCLES : DIV_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_COMB, S_MRST, S_MRUN, S_DSTART, S_DGRACE, S_DWAIT, S_DABORT, S_RESP
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       opc_q, opc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       op_a_q, op_a_d, op_b_q, op_b_d;
   logic             op_cin_q, op_cin_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             mult_rst_n_q, mult_rst_n_d;
   logic             div_reset_q, div_reset_d;
   logic             div_start_q, div_start_d;
   logic             res_valid_q, res_valid_d;
   logic [15:0]      res_data_q, res_data_d;
   logic             res_flag_q, res_flag_d;

   // Next-state, operand latch and result capture
   always_comb begin
      state_d    = state_q;
      opc_d      = opc_q;
      cnt_d      = cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_cin_d   = op_cin_q;
      res_valid_d = res_valid_q;
      res_data_d = res_data_q;
      res_flag_d = res_flag_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_a_d   = cmd_a;
               op_b_d   = cmd_b;
               op_cin_d = (cmd_op == OP_ADD) ? cmd_cin : 1'b0;
               opc_d    = cmd_op;
               cnt_d    = '0;
               case (cmd_op)
                  OP_MUL:  state_d = S_MRST;
                  OP_DIV:  state_d = (cmd_b == 8'd0) ? S_COMB : S_DSTART;
                  default: state_d = S_COMB;
               endcase
            end
         end
         S_COMB: begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            case (opc_q)
               OP_ADD: begin
                  res_data_d = {8'h00, add_sum};
                  res_flag_d = add_cout;
               end
               OP_SUB: begin
                  res_data_d = {8'h00, sub_diff};
                  res_flag_d = sub_bout;
               end
               default: begin
                  res_data_d = 16'h0000;
                  res_flag_d = 1'b1;
               end
            endcase
         end
         S_MRST: begin
            state_d = S_MRUN;
            cnt_d   = '0;
         end
         S_MRUN: begin
            if (cnt_q == CNT_W'(MULT_CYCLES - 1)) begin
               state_d     = S_RESP;
               res_valid_d = 1'b1;
               res_data_d  = mult_product;
               res_flag_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DSTART: state_d = S_DGRACE;
         S_DGRACE: begin
            state_d = S_DWAIT;
            cnt_d   = '0;
         end
         S_DWAIT: begin
            if (!div_busy || div_by_zero) begin
               state_d     = S_RESP;
               res_valid_d = 1'b1;
               res_data_d  = {div_remainder, div_quotient};
               res_flag_d  = div_by_zero;
            end
`ifdef ALU_SEQ_WATCHDOG_EN
            else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
               state_d = S_DABORT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         S_DABORT: begin
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_data_d  = 16'hFFFF;
            res_flag_d  = 1'b1;
         end
         S_RESP: begin
            if (res_ready) begin
               state_d     = S_IDLE;
               res_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Unit-control outputs are registered versions of the upcoming state
      cmd_ready_d  = (state_d == S_IDLE);
      mult_rst_n_d = (state_d != S_MRST);
      div_start_d  = (state_d == S_DSTART);
`ifdef ALU_SEQ_WATCHDOG_EN
      div_reset_d  = (state_d == S_DABORT);
`else
      div_reset_d  = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         opc_q        <= 2'b00;
         cnt_q        <= '0;
         op_a_q       <= 8'h00;
         op_b_q       <= 8'h00;
         op_cin_q     <= 1'b0;
         cmd_ready_q  <= 1'b0;
         mult_rst_n_q <= 1'b0;
         div_reset_q  <= 1'b1;
         div_start_q  <= 1'b0;
         res_valid_q  <= 1'b0;
         res_data_q   <= 16'h0000;
         res_flag_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         opc_q        <= opc_d;
         cnt_q        <= cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_cin_q     <= op_cin_d;
         cmd_ready_q  <= cmd_ready_d;
         mult_rst_n_q <= mult_rst_n_d;
         div_reset_q  <= div_reset_d;
         div_start_q  <= div_start_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_flag_q   <= res_flag_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign op_cin     = op_cin_q;
   assign mult_rst_n = mult_rst_n_q;
   assign div_reset  = div_reset_q;
   assign div_start  = div_start_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_flag   = res_flag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with behavioural ALU unit models and a reference model.
module tb_alu_op_sequencer;

   localparam int MC = 11;

   logic        clk = 1'b0;
   logic        rst_n, cmd_valid, cmd_ready, cmd_cin, op_cin;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_a, cmd_b, op_a, op_b;
   logic [7:0]  add_sum, sub_diff, div_quotient, div_remainder;
   logic        add_cout, sub_bout, mult_rst_n, div_reset, div_start, div_busy, div_by_zero;
   logic [15:0] mult_product, res_data;
   logic        res_valid, res_ready, res_flag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.MULT_CYCLES(MC), .DIV_TIMEOUT(32)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
      .add_sum(add_sum), .add_cout(add_cout), .sub_diff(sub_diff), .sub_bout(sub_bout),
      .mult_rst_n(mult_rst_n), .mult_product(mult_product), .div_reset(div_reset),
      .div_start(div_start), .div_quotient(div_quotient), .div_remainder(div_remainder),
      .div_busy(div_busy), .div_by_zero(div_by_zero), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_flag(res_flag)
   );

   // Adder and subtracter units (sub_bout = 1 means no borrow)
   logic [8:0] add_full;
   assign add_full = 9'(op_a) + 9'(op_b) + 9'(op_cin);
   assign add_sum  = add_full[7:0];
   assign add_cout = add_full[8];
   assign sub_diff = op_a - op_b;
   assign sub_bout = (op_a >= op_b);

   // Multiplier: product only valid once enough cycles have elapsed since reset release
   int mcount = 0;
   int mlow   = 0;
   logic signed [15:0] ma, mb, mp;
   assign ma = {{8{op_a[7]}}, op_a};
   assign mb = {{8{op_b[7]}}, op_b};
   assign mp = ma * mb;
   assign mult_product = (mult_rst_n && mcount >= MC - 1) ? mp : 16'hDEAD;
   always @(posedge clk) begin
      if (!mult_rst_n) mcount <= 0;
      else if (mcount < 1000) mcount <= mcount + 1;
      if (rst_n && !mult_rst_n) mlow <= mlow + 1;
   end

   // Divider: variable latency, garbage outputs while busy, optional stuck-busy fault
   int   div_lat = 0;
   logic stuck   = 1'b0;
   int   d_left  = 0;
   int   starts  = 0;
   int   dres    = 0;
   logic d_busy  = 1'b0;
   logic [7:0] d_q = 8'h00, d_r = 8'h00;
   always @(posedge clk) begin
      if (div_reset) begin
         d_busy <= 1'b0;
      end else if (div_start) begin
         d_busy <= 1'b1;
         d_left <= div_lat;
         d_q    <= (op_b != 0) ? op_a / op_b : 8'hFF;
         d_r    <= (op_b != 0) ? op_a % op_b : op_a;
         starts <= starts + 1;
      end else if (d_busy && !stuck) begin
         if (d_left == 0) d_busy <= 1'b0;
         else d_left <= d_left - 1;
      end
      if (rst_n && div_reset) dres <= dres + 1;
   end
   assign div_busy      = d_busy;
   assign div_quotient  = d_busy ? 8'h5A : d_q;
   assign div_remainder = d_busy ? 8'hA5 : d_r;
   assign div_by_zero   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result from the opcode rules
   function automatic void ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                     input logic cin, output logic [15:0] d, output logic f);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (op)
         2'd0: begin r = ia + ib + int'(cin); d = {8'h00, 8'(r)}; f = (r > 255); end
         2'd1: begin r = ia - ib; d = {8'h00, 8'(r)}; f = (ia >= ib); end
         2'd2: begin
            if (a[7]) ia = ia - 256;
            if (b[7]) ib = ib - 256;
            r = ia * ib; d = 16'(r); f = 1'b0;
         end
         default: begin
            if (b == 8'd0) begin d = 16'h0000; f = 1'b1; end
            else begin d = {8'(ia % ib), 8'(ia / ib)}; f = 1'b0; end
         end
      endcase
   endfunction

   // Issue one command, check operand latch, latency, result, hold stability and release
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input int hold, input logic wd_abort);
      logic [15:0] exp_d, held;
      logic        exp_f;
      int n, edges, m0, s0, r0;
      ref_model(op, a, b, cin, exp_d, exp_f);
      if (wd_abort) begin exp_d = 16'hFFFF; exp_f = 1'b1; end
      n = 0;
      while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
      check("ready_before_cmd", 32'(cmd_ready), 32'd1);
      m0 = mlow; s0 = starts; r0 = dres;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
      @(posedge clk); #1;
      check("ready_drop", 32'(cmd_ready), 32'd0);
      check("op_latch", {8'h00, op_a, op_b, 7'd0, op_cin}, {8'h00, a, b, 7'd0, (op == 2'd0) ? cin : 1'b0});
      cmd_op = 2'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_cin = 1'($urandom);
      edges = 1;
      while (!res_valid && edges < 300) begin @(posedge clk); #1; edges++; end
      cmd_valid = 1'b0;
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_data", 32'(res_data), 32'(exp_d));
      check("res_flag", 32'(res_flag), 32'(exp_f));
      check("op_stable", {16'h0000, op_a, op_b}, {16'h0000, a, b});
      if (op == 2'd2) begin
         check("mul_latency", 32'(edges), 32'(2 + MC));
         check("mult_rst_low", 32'(mlow - m0), 32'd1);
      end else if (op != 2'd3 || b == 8'd0) begin
         check("comb_latency", 32'(edges), 32'd2);
      end
      if (op == 2'd3) check("div_starts", 32'(starts - s0), (b == 8'd0) ? 32'd0 : 32'd1);
      check("div_reset_pulses", 32'(dres - r0), wd_abort ? 32'd1 : 32'd0);
      held = res_data;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold", {14'd0, res_valid, cmd_ready, res_data}, {14'd0, 1'b1, 1'b0, held});
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("release", {30'd0, res_valid, cmd_ready}, 32'd1);
   endtask

   initial begin
      logic [1:0] rop;
      logic [7:0] ra, rb;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_a = 8'd0; cmd_b = 8'd0;
      cmd_cin = 1'b0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(cmd_ready), 32'd0);
      check("rst_res", {14'd0, res_valid, res_flag, res_data}, 32'd0);
      check("rst_ops", {15'd0, op_cin, op_a, op_b}, 32'd0);
      check("rst_units", {29'd0, mult_rst_n, div_reset, div_start}, 32'b010);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_units", {29'd0, cmd_ready, mult_rst_n, div_reset}, 32'b110);

      // Directed vectors
      run_cmd(2'd0, 8'd200, 8'd100, 1'b1, 0, 1'b0);
      run_cmd(2'd1, 8'd50, 8'd70, 1'b1, 0, 1'b0);
      run_cmd(2'd1, 8'd100, 8'd24, 1'b0, 1, 1'b0);
      run_cmd(2'd2, 8'hFD, 8'd6, 1'b1, 0, 1'b0);
      run_cmd(2'd2, 8'hFE, 8'hF9, 1'b0, 0, 1'b0);
      div_lat = 3;
      run_cmd(2'd3, 8'd27, 8'd5, 1'b0, 0, 1'b0);
      run_cmd(2'd3, 8'd42, 8'd0, 1'b0, 0, 1'b0);
      run_cmd(2'd0, 8'hFF, 8'h00, 1'b1, 5, 1'b0);

      // Reset in the middle of a multiply aborts without a response
      cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 8'd9; cmd_b = 8'd9;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_state", {27'd0, res_valid, cmd_ready, mult_rst_n, div_reset, div_start}, 32'b00010);
      check("midrst_ops", {16'd0, op_a, op_b}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_rel", {29'd0, cmd_ready, mult_rst_n, div_reset}, 32'b110);
      repeat (MC + 3) @(posedge clk);
      #1;
      check("midrst_noresp", {30'd0, res_valid, cmd_ready}, 32'b01);

`ifdef ALU_SEQ_WATCHDOG_EN
      stuck = 1'b1;
      run_cmd(2'd3, 8'd100, 8'd3, 1'b0, 0, 1'b1);
      stuck = 1'b0;
`endif

      // Randomised commands
      for (int k = 0; k < 40; k++) begin
         rop = 2'($urandom);
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         if (rop == 2'd3 && $urandom_range(0, 3) == 0) rb = 8'd0;
         div_lat = $urandom_range(0, 12);
         run_cmd(rop, ra, rb, 1'($urandom), $urandom_range(0, 3), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
